// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor, one register stage per prefix level.
// Valid/ready on both ends, global stall, synchronous flush.
module prefix_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    generate
        if (WIDTH != 4 && WIDTH != 8 && WIDTH != 16 &&
            WIDTH != 32 && WIDTH != 64) begin : g_bad_width
            $error("prefix_adder_pipe: WIDTH must be a power of 2 in 4..64");
        end
    endgenerate

    logic             stall;
    logic [WIDTH-1:0] bx;
    logic             cx;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign bx       = in_b ^ {WIDTH{in_sub}};
    assign cx       = in_sub | in_cin;

    // Prefix vectors carry one extra low position holding the carry-in.
    logic [LEVELS:0]  v_q;
    logic [WIDTH:0]   g_q  [LEVELS+1];
    logic [WIDTH:0]   p_q  [LEVELS+1];
    logic [WIDTH-1:0] pb_q [LEVELS+1];
    logic [WIDTH:0]   g_d  [LEVELS+1];
    logic [WIDTH:0]   p_d  [LEVELS+1];

    always_comb begin
        for (int k = 0; k <= LEVELS; k++) begin
            g_d[k] = '0;
            p_d[k] = '0;
        end
        g_d[0] = {in_a & bx, cx};
        p_d[0] = {in_a ^ bx, 1'b0};
        for (int k = 1; k <= LEVELS; k++) begin
            for (int j = 0; j <= WIDTH; j++) begin
                if (j >= (1 << (k - 1))) begin
                    g_d[k][j] = g_q[k-1][j] |
                                (p_q[k-1][j] & g_q[k-1][j - (1 << (k - 1))]);
                    p_d[k][j] = p_q[k-1][j] & p_q[k-1][j - (1 << (k - 1))];
                end else begin
                    g_d[k][j] = g_q[k-1][j];
                    p_d[k][j] = p_q[k-1][j];
                end
            end
        end
    end

    logic [WIDTH:0]   gl;
    logic             pl_msb;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    // The top position still misses the carry-in after LEVELS levels.
    assign gl     = g_q[LEVELS];
    assign pl_msb = p_q[LEVELS][WIDTH];
    assign sum_d  = pb_q[LEVELS] ^ gl[WIDTH-1:0];
    assign cout_d = gl[WIDTH] | (pl_msb & gl[0]);
    assign ovf_d  = gl[WIDTH-1] ^ cout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            for (int k = 0; k <= LEVELS; k++) begin
                g_q[k]  <= '0;
                p_q[k]  <= '0;
                pb_q[k] <= '0;
            end
        end else if (flush) begin
            v_q       <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            v_q     <= {v_q[LEVELS-1:0], in_valid};
            pb_q[0] <= in_a ^ bx;
            for (int k = 1; k <= LEVELS; k++) begin
                pb_q[k] <= pb_q[k-1];
            end
            for (int k = 0; k <= LEVELS; k++) begin
                g_q[k] <= g_d[k];
                p_q[k] <= p_d[k];
            end
            out_valid <= v_q[LEVELS];
            out_sum   <= sum_d;
            out_cout  <= cout_d;
            out_ovf   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe at WIDTH 4, 16 and 64.
// Stimulus pushes expected results; per-width monitors pop and compare.
module tb_prefix_adder_pipe;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          t;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        iv16 = 0, ir16, cin16 = 0, sub16 = 0, ov16, ord16 = 1;
    logic        co16, of16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    logic        iv4 = 0, ir4, cin4 = 0, sub4 = 0, ov4, co4, of4;
    logic [3:0]  a4 = 0, b4 = 0, s4;
    logic        iv64 = 0, ir64, cin64 = 0, sub64 = 0, ov64, co64, of64;
    logic [63:0] a64 = 0, b64 = 0, s64;

    exp_t q16[$];
    exp_t q4[$];
    exp_t q64[$];

    prefix_adder_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .in_cin(cin16), .in_sub(sub16), .out_valid(ov16),
        .out_ready(ord16), .out_sum(s16), .out_cout(co16), .out_ovf(of16));

    prefix_adder_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
        .in_cin(cin4), .in_sub(sub4), .out_valid(ov4),
        .out_ready(1'b1), .out_sum(s4), .out_cout(co4), .out_ovf(of4));

    prefix_adder_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(iv64), .in_ready(ir64), .in_a(a64), .in_b(b64),
        .in_cin(cin64), .in_sub(sub64), .out_valid(ov64),
        .out_ready(1'b1), .out_sum(s64), .out_cout(co64), .out_ovf(of64));

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain wide addition, sign rule for overflow.
    function automatic logic [65:0] mdl(int w, logic [63:0] a,
                                        logic [63:0] b, logic cin,
                                        logic sub);
        logic [63:0] m, bb, s;
        logic [64:0] full;
        logic        c, o;
        m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        bb   = (sub ? ~b : b) & m;
        full = {1'b0, a & m} + {1'b0, bb} + {64'd0, (sub | cin)};
        s    = full[63:0] & m;
        c    = (w == 64) ? full[64] : full[w];
        o    = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
        return {o, c, s};
    endfunction

    task automatic send(logic [15:0] a, logic [15:0] b, logic cin,
                        logic sub, bit push, bit lat, logic [15:0] es,
                        logic ec, logic eo);
        int  n = 0;
        bit  acc = 0;
        int  t = 0;
        exp_t e;
        a16 = a; b16 = b; cin16 = cin; sub16 = sub; iv16 = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ir16;
            t = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else if (push) begin
            e = '{sum: {48'd0, es}, cout: ec, ovf: eo, t: t, lat: lat};
            q16.push_back(e);
        end
    endtask

    task automatic sendm(logic [15:0] a, logic [15:0] b, logic cin,
                         logic sub, bit lat);
        logic [65:0] r;
        r = mdl(16, {48'd0, a}, {48'd0, b}, cin, sub);
        send(a, b, cin, sub, 1'b1, lat, r[15:0], r[64], r[65]);
    endtask

    task automatic idle(int n);
        iv16 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit          held = 0;
    logic [15:0] hold_sum;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ov16 && ord16) begin
                if (q16.size() == 0) begin
                    chk("w16_unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = q16.pop_front();
                    chk("w16_sum", {48'd0, s16}, e.sum);
                    chk("w16_cout", {63'd0, co16}, {63'd0, e.cout});
                    chk("w16_ovf", {63'd0, of16}, {63'd0, e.ovf});
                    if (e.lat)
                        chk("w16_latency", 64'(cyc - e.t), 64'd6);
                end
            end
            if (ov16 && !ord16) begin
                chk("w16_in_ready_stall", {63'd0, ir16}, 64'd0);
                if (held) chk("w16_stall_stable", {48'd0, s16}, {48'd0, hold_sum});
                held = 1;
                hold_sum = s16;
            end else begin
                held = 0;
            end
        end else begin
            held = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov4) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                chk("w4_res", {58'd0, of4, co4, s4},
                    {58'd0, e.ovf, e.cout, e.sum[3:0]});
            end
        end
        if (rst_n && ov64) begin
            if (q64.size() == 0) begin
                chk("w64_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = q64.pop_front();
                chk("w64_sum", s64, e.sum);
                chk("w64_flags", {62'd0, of64, co64}, {62'd0, e.ovf, e.cout});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [65:0] r;
        exp_t        e;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, ov16}, 64'd0);
        chk("reset_out_sum", {47'd0, of16, s16}, 64'd0);
        chk("reset_cout", {63'd0, co16}, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Directed vectors, hand-computed.
        send(16'h1234, 16'h4321, 0, 0, 1, 1, 16'h5555, 0, 0);
        idle(10);
        send(16'hFFFF, 16'h0001, 1, 0, 1, 1, 16'h0001, 1, 0);
        send(16'h7FFF, 16'h0001, 0, 0, 1, 1, 16'h8000, 0, 1);
        send(16'h0005, 16'h0007, 1, 1, 1, 1, 16'hFFFE, 0, 0);
        send(16'h8000, 16'h0001, 0, 1, 1, 1, 16'h7FFF, 1, 1);
        idle(10);

        // Back-to-back stream with a 3-cycle output stall.
        fork
            begin
                for (int i = 0; i < 20; i++)
                    sendm(16'(i * 16'h1111 + 16'h0F0F), 16'(16'hA5A5 ^ (i * 7)),
                          1'(i), 1'(i >> 1), 0);
                iv16 = 1'b0;
            end
            begin
                repeat (9) @(posedge clk);
                #1;
                ord16 = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                ord16 = 1'b1;
            end
        join
        idle(15);

        // Flush with 4 ops in flight; the op presented with flush is dropped.
        for (int i = 0; i < 4; i++)
            send(16'(i + 1), 16'h0100, 0, 0, 0, 0, 16'h0, 0, 0);
        a16 = 16'hDEAD; b16 = 16'h0001; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        iv16 = 1'b0;
        @(posedge clk);
        #1;
        send(16'h00FF, 16'h0F01, 0, 0, 1, 1, 16'h1000, 0, 0);
        idle(12);

        // Asynchronous reset while a result is held at the output.
        ord16 = 1'b0;
        for (int i = 0; i < 3; i++)
            send(16'(i + 5), 16'h0002, 0, 0, 0, 0, 16'h0, 0, 0);
        iv16 = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_valid", {63'd0, ov16}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", {63'd0, ov16}, 64'd0);
        chk("async_reset_sum", {48'd0, s16}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ord16 = 1'b1;
        idle(10);

        // Random add/sub sweep on all three widths.
        for (int i = 0; i < 40; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom);
            cin4 = 1'($urandom); sub4 = 1'($urandom);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            cin64 = 1'($urandom); sub64 = 1'($urandom);
            if (i == 0) begin a64 = '1; b64 = 64'd1; cin64 = 0; sub64 = 0; end
            if (i == 1) begin a64 = 64'h8000_0000_0000_0000; b64 = 64'd1; sub64 = 1; end
            iv4 = 1'b1;
            iv64 = 1'b1;
            @(negedge clk);
            if (ir4) begin
                r = mdl(4, {60'd0, a4}, {60'd0, b4}, cin4, sub4);
                e = '{sum: r[63:0], cout: r[64], ovf: r[65], t: cyc, lat: 0};
                q4.push_back(e);
            end
            if (ir64) begin
                r = mdl(64, a64, b64, cin64, sub64);
                e = '{sum: r[63:0], cout: r[64], ovf: r[65], t: cyc, lat: 0};
                q64.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        iv4 = 1'b0;
        iv64 = 1'b0;
        for (int i = 0; i < 40; i++)
            sendm(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
        idle(15);

        chk("q16_drained", 64'(q16.size()), 64'd0);
        chk("q4_drained", 64'(q4.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
